// File: rtl/audio_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_pkg
// Description : Shared definitions for the audio_out_i2s block.
//               - Register map addresses.
//               - CTRL and STATUS bit positions.
//               - Serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_out_pkg;

    // Register map (word addresses on the Avalon-MM slave)
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLEAR_BIT  = 2;
    localparam int CTRL_ATTEN_LSB  = 4;
    localparam int CTRL_ATTEN_MSB  = 7;

    // STATUS bit positions (level occupies [15:0])
    localparam int STAT_EMPTY_BIT    = 16;
    localparam int STAT_FULL_BIT     = 17;
    localparam int STAT_UNDERRUN_BIT = 18;
    localparam int STAT_OVERFLOW_BIT = 19;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } serializer_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_out_i2s_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous single-clock show-ahead FIFO.
//               - A push is accepted only while not full.
//               - A pop is honoured only while not empty.
//               - A push and a pop in the same cycle both take effect.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push/i_wdata - write strobe and data
//               i_pop          - read strobe (o_rdata is the head entry)
//               o_full/o_empty - occupancy flags
//               o_level        - entry count, 0..DEPTH inclusive
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int c_addr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_level_w = $clog2(DEPTH + 1);
    localparam logic [c_level_w-1:0] c_level_full = c_level_w'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [c_level_w-1:0] r_level;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_level == c_level_full);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_out_i2s.sv
`default_nettype none
// ============================================================================
// Module      : audio_out_i2s
// Description : Avalon-MM sample FIFO feeding an I2S serializer (WM8731 DAC).
//               Software pushes interleaved L/R samples (left first).
//               BCLK/LRCK are derived from clk. A level-high IRQ flags
//               low-water, underrun and overflow.
// Ports       : clk, reset              - system clock, sync active-high reset
//               chipselect/write/read   - Avalon-MM strobes
//               address, writedata      - register select, write data
//               readdata                - registered read data (1-cycle latency)
//               irq                     - interrupt, level-high
//               aud_bclk/aud_daclrck/aud_dacdat - I2S conduit
// Options     : AUDIO_OUT_VOLUME_EN - when defined, CTRL[7:4] is an
//               arithmetic right-shift attenuation applied at sample load.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_out_i2s
    import audio_out_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int DEPTH    = 256,
    parameter int BCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat
);

    localparam int c_level_w = $clog2(DEPTH + 1);
    localparam int c_div_w   = $clog2(BCLK_DIV);
    localparam int c_bit_w   = $clog2(SLOT_W);
    localparam int c_pad_w   = SLOT_W - SAMPLE_W;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(SLOT_W - 1);

    // ---------------------------------------------------------------- bus
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_push;
    logic        w_ctrl_wr;
    logic        w_thresh_wr;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic        r_enable;
    logic        r_irq_en;
    logic [15:0] r_thresh;
    logic        r_underrun;
    logic        r_overflow;
    logic        r_irq;
    logic [31:0] r_readdata;
    logic [3:0]  w_atten;

    // ---------------------------------------------------------------- fifo
    logic [SAMPLE_W-1:0]  w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_level_w-1:0] w_fifo_level;
    logic [15:0]          w_level16;
    logic                 w_pop;

    // ---------------------------------------------------------- serializer
    serializer_state_t    r_state;
    logic [c_div_w-1:0]   r_div_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic                 r_bclk;
    logic                 r_lrck;
    logic                 r_dacdat;
    logic [SLOT_W-1:0]    r_shift;
    logic                 w_bclk_fall;
    logic                 w_slot_start;
    logic [SAMPLE_W-1:0]  w_sample;
    logic [SAMPLE_W-1:0]  w_scaled;
    logic [SLOT_W-1:0]    w_load;

    assign w_wr_en     = chipselect & write;
    assign w_rd_en     = chipselect & read;
    assign w_push      = w_wr_en & (address == REG_DATA);
    assign w_ctrl_wr   = w_wr_en & (address == REG_CTRL);
    assign w_thresh_wr = w_wr_en & (address == REG_THRESH);
    // Only a subset of writedata bits is mapped in any configuration.
    assign w_unused    = ^writedata;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (writedata[SAMPLE_W-1:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign w_level16 = 16'(w_fifo_level);

    // bclk_fall coincides with the clk edge that drives aud_bclk 1->0.
    assign w_bclk_fall  = (r_state == RUN) & (r_div_cnt == c_div_last) & r_bclk;
    assign w_slot_start = w_bclk_fall & (r_bit_cnt == '0);
    assign w_pop        = w_slot_start & ~w_fifo_empty;
    // An empty FIFO at slot start serializes silence.
    assign w_sample     = w_fifo_empty ? '0 : w_fifo_rdata;

`ifdef AUDIO_OUT_VOLUME_EN
    logic [3:0] r_atten;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_atten <= '0;
        end else if (w_ctrl_wr) begin
            r_atten <= writedata[CTRL_ATTEN_MSB:CTRL_ATTEN_LSB];
        end
    end

    assign w_atten  = r_atten;
    assign w_scaled = $signed(w_sample) >>> r_atten;
`else
    assign w_atten  = 4'd0;
    assign w_scaled = w_sample;
`endif

    // MSB-aligned within the slot, low bits zero-padded.
    assign w_load = {w_scaled, {c_pad_w{1'b0}}};

    // ------------------------------------------------------ register read
    always_comb begin
        w_rdata = '0;
        case (address)
            REG_STATUS: begin
                w_rdata[15:0]              = w_level16;
                w_rdata[STAT_EMPTY_BIT]    = w_fifo_empty;
                w_rdata[STAT_FULL_BIT]     = w_fifo_full;
                w_rdata[STAT_UNDERRUN_BIT] = r_underrun;
                w_rdata[STAT_OVERFLOW_BIT] = r_overflow;
            end
            REG_CTRL: begin
                w_rdata[CTRL_ENABLE_BIT]               = r_enable;
                w_rdata[CTRL_IRQ_EN_BIT]               = r_irq_en;
                w_rdata[CTRL_ATTEN_MSB:CTRL_ATTEN_LSB] = w_atten;
            end
            REG_THRESH: begin
                w_rdata[15:0] = r_thresh;
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    // ------------------------------------------ control, flags, irq, read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_thresh   <= 16'(DEPTH / 2);
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= writedata[CTRL_ENABLE_BIT];
                r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
            end
            if (w_thresh_wr) begin
                r_thresh <= writedata[15:0];
            end
            // A new event in the clearing cycle is kept, so none is lost.
            if (w_ctrl_wr && writedata[CTRL_CLEAR_BIT]) begin
                r_underrun <= 1'b0;
                r_overflow <= 1'b0;
            end
            if (w_slot_start && w_fifo_empty) begin
                r_underrun <= 1'b1;
            end
            if (w_push && w_fifo_full) begin
                r_overflow <= 1'b1;
            end
            r_irq <= r_irq_en & ((r_enable & (w_level16 < r_thresh)) |
                                 r_underrun | r_overflow);
            if (w_rd_en) begin
                r_readdata <= w_rdata;
            end
        end
    end

    // ------------------------------------------------------- serializer
    // Data changes on bclk_fall so the DAC sees it stable at the BCLK rise.
    // The load at bit 0 lands one BCLK after the LRCK edge (I2S delay).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_dacdat  <= 1'b0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_bclk    <= 1'b0;
                    r_lrck    <= 1'b0;
                    r_dacdat  <= 1'b0;
                    r_shift   <= '0;
                    if (r_enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_div_cnt == c_div_last) begin
                        r_div_cnt <= '0;
                        r_bclk    <= ~r_bclk;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                    if (w_bclk_fall) begin
                        if (r_bit_cnt == '0) begin
                            r_dacdat <= w_load[SLOT_W-1];
                            r_shift  <= w_load << 1;
                        end else begin
                            r_dacdat <= r_shift[SLOT_W-1];
                            r_shift  <= r_shift << 1;
                        end
                        if (r_bit_cnt == c_bit_last) begin
                            r_bit_cnt <= '0;
                            if (r_enable) begin
                                r_lrck <= ~r_lrck;
                            end else begin
                                // Disable takes effect only on a slot boundary.
                                r_state   <= IDLE;
                                r_div_cnt <= '0;
                                r_bclk    <= 1'b0;
                                r_lrck    <= 1'b0;
                                r_dacdat  <= 1'b0;
                                r_shift   <= '0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign readdata    = r_readdata;
    assign irq         = r_irq;
    assign aud_bclk    = r_bclk;
    assign aud_daclrck = r_lrck;
    assign aud_dacdat  = r_dacdat;

endmodule
`default_nettype wire

// File: tb/tb_audio_out_i2s.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_out_i2s
// Description : Directed self-checking bench for audio_out_i2s
//               (SAMPLE_W=16, SLOT_W=32, DEPTH=256, BCLK_DIV=2).
//               Honours AUDIO_OUT_VOLUME_EN for the attenuation step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_out_i2s;
    import audio_out_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;

    int n_tests  = 0;
    int n_fail   = 0;
    int timeouts = 0;

    always #5 clk = ~clk;

    audio_out_i2s #(
        .SAMPLE_W (16),
        .SLOT_W   (32),
        .DEPTH    (256),
        .BCLK_DIV (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Returns once a BCLK rising edge is seen; cycles = clk periods waited.
    task automatic wait_rise(output int cycles);
        logic prev;
        cycles = 0;
        while (cycles < 64) begin
            prev = aud_bclk;
            tick();
            cycles++;
            if (!prev && aud_bclk) return;
        end
        timeouts++;
    endtask

    // Samples DAT and LRCK on 32 consecutive BCLK rises, first sample in MSB.
    task automatic capture_slot(output logic [31:0] bits, output logic [31:0] lr);
        int c;
        bits = '0;
        lr   = '0;
        for (int i = 0; i < 32; i++) begin
            wait_rise(c);
            bits = {bits[30:0], aud_dacdat};
            lr   = {lr[30:0], aud_daclrck};
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] bits;
        logic [31:0] lr;
        logic [15:0] expv;
        logic        dat_seen;
        logic        prev_irq;
        logic        found;
        int          c;
        int          errs;

        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0;

        // ---------------------------------------------------- reset values
        do_reset();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_audio", {29'd0, aud_bclk, aud_daclrck, aud_dacdat}, 32'h0);
        bus_read(REG_STATUS, rd);
        check("rst_status", rd, 32'h0001_0000);
        bus_read(REG_THRESH, rd);
        check("rst_thresh", rd, 32'd128);
        bus_read(REG_CTRL, rd);
        check("rst_ctrl", rd, 32'h0);

        // ---------------------------------------------------- serial frame
        bus_write(REG_DATA, 32'h0000_8001);
        bus_write(REG_DATA, 32'h0000_7FFE);
        bus_read(REG_STATUS, rd);
        check("frame_level", rd, 32'h0000_0002);
        bus_write(REG_CTRL, 32'h1);
        wait_rise(c);                      // first rise precedes any data
        capture_slot(bits, lr);
        check("frame_left_dat", bits, 32'h8001_0000);
        check("frame_left_lrck", lr, 32'h0000_0001);
        capture_slot(bits, lr);
        check("frame_right_dat", bits, 32'h7FFE_0000);
        check("frame_right_lrck", lr, 32'hFFFF_FFFE);
        wait_rise(c);
        check("bclk_period", c, 32'd4);
        check("frame_timeout", timeouts, 32'd0);
        bus_write(REG_CTRL, 32'h0);
        repeat (300) tick();
        bus_read(REG_STATUS, rd);
        check("frame_drain_status", rd, 32'h0005_0000);
        check("disable_idle_audio", {29'd0, aud_bclk, aud_daclrck, aud_dacdat}, 32'h0);

        // -------------------------------------------------------- underrun
        do_reset();
        bus_write(REG_CTRL, 32'h1);
        dat_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            dat_seen = dat_seen | aud_dacdat;
        end
        check("udr_dat_zero", {31'd0, dat_seen}, 32'h0);
        bus_read(REG_STATUS, rd);
        check("udr_status", rd, 32'h0005_0000);
        bus_write(REG_THRESH, 32'h0);
        check("udr_irq_off", {31'd0, irq}, 32'h0);
        bus_write(REG_CTRL, 32'h3);
        tick();
        check("udr_irq_on", {31'd0, irq}, 32'h1);
        bus_write(REG_CTRL, 32'h2);
        repeat (300) tick();
        check("udr_irq_sticky", {31'd0, irq}, 32'h1);
        bus_write(REG_CTRL, 32'h6);
        check("udr_irq_before_drop", {31'd0, irq}, 32'h1);
        tick();
        check("udr_irq_dropped", {31'd0, irq}, 32'h0);
        bus_read(REG_STATUS, rd);
        check("udr_cleared_status", rd, 32'h0001_0000);
        bus_read(REG_CTRL, rd);
        check("udr_ctrl_readback", rd, 32'h2);

        // ------------------------------------------------ full / overflow
        do_reset();
        for (int k = 1; k <= 257; k++) begin
            bus_write(REG_DATA, 32'((k * 37) & 16'hFFFF));
        end
        bus_read(REG_STATUS, rd);
        check("ovf_status", rd, 32'h000A_0100);
        bus_write(REG_CTRL, 32'h1);
        wait_rise(c);
        errs = 0;
        for (int s = 0; s < 256; s++) begin
            capture_slot(bits, lr);
            expv = 16'(((s + 1) * 37) & 16'hFFFF);
            if (bits !== {expv, 16'h0000}) errs++;
        end
        check("ovf_256_samples_errs", errs, 32'd0);
        capture_slot(bits, lr);
        check("ovf_257th_dropped", bits, 32'h0);
        bus_read(REG_STATUS, rd);
        check("ovf_final_status", rd, 32'h000D_0000);
        check("ovf_timeout", timeouts, 32'd0);

        // -------------------------------------------------- threshold irq
        do_reset();
        bus_write(REG_THRESH, 32'd4);
        for (int k = 0; k < 6; k++) bus_write(REG_DATA, 32'h1111 * (k + 1));
        bus_write(REG_CTRL, 32'h3);
        chipselect = 1'b1; read = 1'b1; address = REG_STATUS;
        prev_irq = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (readdata[15:0] == 16'd4) prev_irq = irq;
            if (readdata[15:0] == 16'd3) begin
                found = 1'b1;
                check("thr_irq_at_4", {31'd0, prev_irq}, 32'h0);
                check("thr_irq_at_3", {31'd0, irq}, 32'h1);
            end
        end
        chipselect = 1'b0; read = 1'b0;
        check("thr_level3_reached", {31'd0, found}, 32'h1);

        // --------------------------------------------- reset mid-frame
        wait_rise(c);
        reset = 1'b1;
        tick();
        check("midrst_outputs", {28'd0, irq, aud_bclk, aud_daclrck, aud_dacdat}, 32'h0);
        reset = 1'b0;
        tick();
        check("midrst_timeout", timeouts, 32'd0);

        // ---------------------------------------------------------- volume
        do_reset();
        bus_write(REG_DATA, 32'h0000_8000);
        bus_write(REG_CTRL, 32'h21);
        bus_read(REG_CTRL, rd);
        wait_rise(c);
        capture_slot(bits, lr);
`ifdef AUDIO_OUT_VOLUME_EN
        check("vol_ctrl_readback", rd, 32'h21);
        check("vol_serial", bits, 32'hE000_0000);
`else
        check("vol_ctrl_readback", rd, 32'h01);
        check("vol_serial", bits, 32'h8000_0000);
`endif
        check("vol_timeout", timeouts, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_out_i2s.md
Name: audio_out_i2s

Overview:
Parametrised successor to the fixed audio-out driver interface. It is an Avalon-MM slave sample FIFO feeding an I2S serializer for the WM8731 DAC (AUD_BCLK/AUD_DACLRCK/AUD_DACDAT).
- HPS software pushes interleaved L/R samples.
- The block generates bit and word clocks from the system clock.
- It raises a level-triggered IRQ when the FIFO drains below a programmable threshold.
- It sits inside soc_system as a Qsys component; its conduit goes to the audio pins in the top level.

Parameters:
SAMPLE_W, 16, sample width in bits (16..24)
SLOT_W, 32, BCLK periods per channel slot (>= SAMPLE_W+1)
DEPTH, 256, FIFO depth in samples (power of 2)
BCLK_DIV, 16, clk cycles per BCLK half-period (>= 2)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
chipselect  in  1  Avalon select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  2  register select
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  interrupt, level-high
aud_bclk  out  1  I2S bit clock
aud_daclrck  out  1  I2S word clock (0 = left)
aud_dacdat  out  1  serial DAC data

Behaviour:
- Registers:
  - addr0 DATA (W): push writedata[SAMPLE_W-1:0]. Channel order is the write order, starting left.
  - addr1 STATUS (R): [15:0] level, [16] empty, [17] full, [18] underrun, [19] overflow.
  - addr2 CTRL (RW): [0] enable, [1] irq_en, [7:4] attenuation (see optional feature). Writing CTRL with [2]=1 clears both sticky flags; bit 2 reads 0.
  - addr3 THRESH (RW): [15:0] low-water level.
- Reset values:
  - Outputs: readdata=0, irq=0, aud_bclk=0, aud_daclrck=0, aud_dacdat=0.
  - FIFO empty; CTRL=0; THRESH=DEPTH/2; sticky flags 0.
  - Reset mid-frame aborts the frame immediately; no partial-bit glitch beyond the reset cycle.
- Read: readdata is valid one cycle after chipselect&read. Unmapped bits read 0.
- Push:
  - A write while full is dropped and sets overflow.
  - A push and a pop in the same cycle both occur; level is unchanged.
  - Level counts 0..DEPTH inclusive.
- Clock generation:
  - div counter 0..BCLK_DIV-1; aud_bclk toggles at wrap.
  - bclk_fall is a one-cycle tick when aud_bclk goes 1->0.
  - The bit counter (0..SLOT_W-1) advances on bclk_fall. At wrap, aud_daclrck toggles.
- Serializer FSM:
  - IDLE: enable=0. BCLK, LRCK and DAT held 0; counters held 0. The FIFO still accepts writes.
  - RUN: entered the cycle after enable is set; first slot is left (LRCK=0).
  - Clearing enable returns to IDLE at the next slot boundary.
  - Slot start (bit counter 0, at bclk_fall):
    - Pop one sample into the shift register, MSB-aligned, low bits zero-padded to SLOT_W.
    - If the FIFO is empty: load 0 and set underrun; no pop.
  - I2S one-bit delay: MSB appears on the bclk_fall after the LRCK edge, then shifts one bit per bclk_fall. The DAC samples on the BCLK rising edge.
- IRQ: registered, irq = irq_en & ((enable & level < THRESH) | underrun | overflow). One cycle latency from level change.

Optional Feature:
AUDIO_OUT_VOLUME_EN:
- Defined: the sample is arithmetic-right-shifted by CTRL[7:4] (0..15, sign-extended) at shift-register load; CTRL[7:4] is read/write.
- Undefined: no shifter; CTRL[7:4] reads 0 and writes are ignored.

Decomposition:
- Package audio_out_pkg:
  - Register address localparams (REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_THRESH=3).
  - CTRL/STATUS bit-index constants.
  - Enum typedef serializer_state_t {IDLE, RUN}.
- Sub-module sample_fifo: synchronous single-clock FIFO, parameters WIDTH/DEPTH, with push/pop/full/empty/level outputs.

Test Plan:
- Reset values, with BCLK_DIV=2, SLOT_W=32, SAMPLE_W=16:
  - Stimulus: assert reset; read STATUS.
  - Response: readdata=0x00010000 (empty); THRESH reads 128; all audio outputs 0; irq=0.
- Serial frame:
  - Stimulus: push 0x8001 then 0x7FFE; set CTRL=1.
  - Response: DAT on LRCK=0 slot is 1,0,...,0,1 starting one BCLK after the LRCK edge, then 16 zeros. The right slot carries 0x7FFE. BCLK period is 4 clk.
- Underrun:
  - Stimulus: enable with the FIFO empty.
  - Response: DAT stays 0; STATUS[18]=1.
  - Stimulus: set irq_en.
  - Response: irq=1.
  - Stimulus: CTRL write with bit2=1.
  - Response: flag clears; irq drops one cycle later.
- Full/overflow (DEPTH=256):
  - Stimulus: 257 pushes while disabled.
  - Response: level=256, full=1, overflow=1; the 257th sample is never output.
- Threshold IRQ:
  - Stimulus: THRESH=4; push 6; enable with irq_en.
  - Response: irq rises exactly one cycle after level goes 4->3.
- Volume (AUDIO_OUT_VOLUME_EN):
  - Stimulus: CTRL[7:4]=2; sample 0x8000.
  - Response: serialized 0xE000.
